writeback: RTL
==============

# writeback

Final pipeline stage of the RISC-V core: consumes the registered `mem_to_wb_s` bundle produced by the memory stage and commits results into the architectural register file. Provides the two decode-stage read ports, with same-cycle write-to-read bypass, a retired-write counter, and a registered commit trace for the testbench. Sits between the memory stage output and the decode stage's operand fetch.

## Interface
- `CNT_WIDTH`, 64, width of the retired-write counter; wraps modulo 2^CNT_WIDTH.
- `BYPASS`, 1, 1 = read ports return the in-flight write value on address match; 0 = read ports return stored array contents only.
- Reset is asynchronous and active-low; clock and reset are named as the codebase does.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_to_wb`  in  `mem_to_wb_s`  result bundle: `data[31:0]`, `reg_write`, `rd[4:0]`.
- `rs1_addr`  in  5  decode read port 1 address.
- `rs1_data`  out  32  decode read port 1 data, combinational.
- `rs2_addr`  in  5  decode read port 2 address.
- `rs2_data`  out  32  decode read port 2 data, combinational.
- `commit_valid`  out  1  registered: a register write was committed in the previous cycle.
- `commit_rd`  out  5  registered rd of that commit.
- `commit_data`  out  32  registered data of that commit.
- `retired_cnt`  out  CNT_WIDTH  number of committed register writes since reset.

## Operation
- Commit condition: `we = mem_to_wb.reg_write && (mem_to_wb.rd != 0)`.
- On each rising edge with `we`: `regs[rd] <= data`; `retired_cnt <= retired_cnt + 1`; `commit_valid <= 1`, `commit_rd <= rd`, `commit_data <= data`.
- On a rising edge without `we`: register array and counter hold; `commit_valid <= 0`; `commit_rd`/`commit_data` hold their last values.
- x0: writes with `rd == 0` are discarded and are neither counted nor traced. Reads of address 0 return 0 regardless of array contents or bypass.
- Read ports (each independent, identical logic):
  - addr 0 -> 0;
  - else if `BYPASS` and `we` and addr == `mem_to_wb.rd` -> `mem_to_wb.data`;
  - else -> `regs[addr]`.
- Both ports reading the same address return the same value. Ports are purely combinational from `rs*_addr` and `mem_to_wb`.
- Counter: unsigned and CNT_WIDTH bits wide. It wraps from all-ones to 0 without any flag.

## Timing
- Write latency: the value is visible from array storage on the cycle after the edge. With `BYPASS=1`, it is also visible in the same cycle it is presented.
- Reset (`rst_n` low, asynchronous, any time including mid-stream): all 31 writable registers = 0, `retired_cnt = 0`, `commit_valid = 0`, `commit_rd = 0`, `commit_data = 0`.
- While `rst_n` is low, writes are ignored. The first commit can occur on the first rising edge after `rst_n` deasserts.
- Back-to-back writes to the same rd on consecutive cycles: the later write wins. A read in the second cycle returns the second cycle's data when `BYPASS=1`.
- The block has no stall or flush input. Each cycle's `mem_to_wb` is exactly one candidate commit, and `reg_write` is the only qualifier.
- No X-propagation tolerance is required on `data` when `reg_write = 0`: such data must never reach the array or the trace outputs.

## Structure
- `mem_to_wb_s` stays in `riscv_structures.sv`.
- Add the following to the same file: `reg_addr_t` (`logic [4:0]`), `xlen_t` (`logic [31:0]`), and constant `REG_ZERO = 5'd0`.
- One sub-module: `register_file`, containing the 32x32 array, x0 handling, asynchronous reset, one write port, two combinational read ports, and the `BYPASS` parameter.
- `writeback` instantiates `register_file`. It owns the commit-condition logic, `retired_cnt` and the commit trace registers.

## Test plan
- Write then read: present `reg_write=1, rd=5, data=0xDEADBEEF`, with `rs1_addr=5` in the same cycle.
  - `BYPASS=1`: `rs1_data=0xDEADBEEF` in that cycle.
  - Next cycle: `commit_valid=1, commit_rd=5, commit_data=0xDEADBEEF, retired_cnt=1`, and the read still returns `0xDEADBEEF` from storage.
- x0 protection: write `rd=0, data=0x12345678, reg_write=1` -> `rs1_addr=0` returns 0, `retired_cnt` unchanged, `commit_valid=0` next cycle.
- `reg_write=0` with `rd=7, data=0xFFFFFFFF` -> `regs[7]` stays 0, counter unchanged. Follow with back-to-back writes `rd=3 data=1`, then `rd=3 data=2` -> `rs2_addr=3` reads 2, `retired_cnt=2`.
- Dual-port: after writing `x1=0xA` and `x2=0xB`, set `rs1_addr=2, rs2_addr=1` -> `rs1_data=0xB, rs2_data=0xA`. Then set both ports to address 2 -> both return `0xB`.
- Mid-stream reset: after 10 writes, assert `rst_n=0` between edges -> immediately all reads 0, `retired_cnt=0`, `commit_*=0`. A write presented during reset is not committed.
- Wrap: build with `CNT_WIDTH=4` and perform 17 writes to `rd=9` -> `retired_cnt=1`, and `regs[9]` holds the 17th data value.

Source files
------------

// File: rtl/riscv_structures.sv
// rtl/riscv_structures.sv - shared core types: register address, XLEN word, memory-to-writeback bundle
package riscv_structures;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

    // x0 is hardwired to zero and never written.
    localparam reg_addr_t REG_ZERO = 5'd0;

    // Registered result bundle handed from the memory stage to writeback.
    typedef struct packed {
        xlen_t     data;
        logic      reg_write;
        reg_addr_t rd;
    } mem_to_wb_s;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 architectural register file, one write port, two combinational read ports
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears x1..x31)
//   we                  write enable for this cycle
//   wr_addr, wr_data    write address and data
//   rs1_addr, rs1_data  read port 1 (combinational)
//   rs2_addr, rs2_data  read port 2 (combinational)
// Parameter BYPASS: nonzero forwards the in-flight write to a matching read port.
module register_file
    import riscv_structures::*;
#(
    parameter int BYPASS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  reg_addr_t wr_addr,
    input  xlen_t     wr_data,
    input  reg_addr_t rs1_addr,
    output xlen_t     rs1_data,
    input  reg_addr_t rs2_addr,
    output xlen_t     rs2_data
);

    // x0 has no storage; index 0 is never allocated.
    xlen_t regs_q [31:1];
    xlen_t regs_d [31:1];

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (we && (wr_addr == 5'(i))) begin
                regs_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Address 0 falls through the loop and reads as zero; the bypass is
    // suppressed for address 0 so x0 stays zero even if a caller asserts we.
    always_comb begin
        rs1_data = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1_addr == 5'(i)) begin
                rs1_data = regs_q[i];
            end
        end
        if ((BYPASS != 0) && we && (rs1_addr == wr_addr) && (rs1_addr != REG_ZERO)) begin
            rs1_data = wr_data;
        end
    end

    always_comb begin
        rs2_data = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs2_addr == 5'(i)) begin
                rs2_data = regs_q[i];
            end
        end
        if ((BYPASS != 0) && we && (rs2_addr == wr_addr) && (rs2_addr != REG_ZERO)) begin
            rs2_data = wr_data;
        end
    end

endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - writeback stage: commits mem_to_wb results, counts retired writes, registers commit trace
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mem_to_wb            result bundle from the memory stage (data, reg_write, rd)
//   rs1_addr, rs1_data   decode read port 1 (combinational)
//   rs2_addr, rs2_data   decode read port 2 (combinational)
//   commit_valid         a write committed on the previous edge
//   commit_rd            rd of the last commit (holds when no commit)
//   commit_data          data of the last commit (holds when no commit)
//   retired_cnt          committed writes since reset, wraps modulo 2^CNT_WIDTH
module writeback
    import riscv_structures::*;
#(
    parameter int CNT_WIDTH = 64,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  mem_to_wb_s           mem_to_wb,
    input  reg_addr_t            rs1_addr,
    output xlen_t                rs1_data,
    input  reg_addr_t            rs2_addr,
    output xlen_t                rs2_data,
    output logic                 commit_valid,
    output reg_addr_t            commit_rd,
    output xlen_t                commit_data,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    logic we;

    logic                 commit_valid_q, commit_valid_d;
    reg_addr_t            commit_rd_q,    commit_rd_d;
    xlen_t                commit_data_q,  commit_data_d;
    logic [CNT_WIDTH-1:0] retired_cnt_q,  retired_cnt_d;

    // Writes to x0 are architectural no-ops: not stored, counted or traced.
    assign we = mem_to_wb.reg_write && (mem_to_wb.rd != REG_ZERO);

    register_file #(
        .BYPASS (BYPASS)
    ) u_register_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wr_addr  (mem_to_wb.rd),
        .wr_data  (mem_to_wb.data),
        .rs1_addr (rs1_addr),
        .rs1_data (rs1_data),
        .rs2_addr (rs2_addr),
        .rs2_data (rs2_data)
    );

    // Trace rd/data only load on a commit so data from non-writing slots
    // (which may be X) never reaches the trace outputs.
    always_comb begin
        commit_valid_d = we;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;
        retired_cnt_d  = retired_cnt_q;
        if (we) begin
            commit_rd_d   = mem_to_wb.rd;
            commit_data_d = mem_to_wb.data;
            retired_cnt_d = retired_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            retired_cnt_q  <= '0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            retired_cnt_q  <= retired_cnt_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;
    assign retired_cnt  = retired_cnt_q;

endmodule
